// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: issues in-order fetches for the PC over a
// req/gnt/rvalid port and queues returned instructions with their PCs for decode.
module ifetch_unit #(
   parameter int          DEPTH = 4,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        stall_out,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        id_ready
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      pc_d   [DEPTH];
   logic [31:0]      inst_q [DEPTH];
   logic [31:0]      inst_d [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
   logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
   logic [PW-1:0]    head_ptr_q, head_ptr_d;
   // alloc_cnt: allocated and not popped; pend_cnt: allocated and not yet filled
   logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
   logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
   logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
   logic [CW:0]      occupancy, drop_sum, drop_sum_m1;
   logic             accept, drop_rsp, fill_rsp, pop;

   assign occupancy   = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
   assign imem_req    = rst & ~flush & (occupancy < DEPTH_W);
   assign imem_addr   = pc_in;
   assign accept      = imem_req & imem_gnt;
   // A flush must let the PC load its redirect target, except while in reset.
   assign stall_out   = ~rst | (~flush & ~accept);
   assign drop_rsp    = imem_rvalid & (drop_cnt_q != '0);
   assign fill_rsp    = imem_rvalid & (drop_cnt_q == '0) & (pend_cnt_q != '0);
   assign inst_valid  = filled_q[head_ptr_q];
   assign inst_out    = inst_valid ? inst_q[head_ptr_q] : NOP;
   assign inst_pc     = inst_valid ? pc_q[head_ptr_q] : 32'h0;
   assign pop         = inst_valid & id_ready & ~flush;
   assign drop_sum    = {1'b0, drop_cnt_q} + {1'b0, pend_cnt_q};
   assign drop_sum_m1 = drop_sum - (CW+1)'(1);

   always_comb begin
      pc_d        = pc_q;
      inst_d      = inst_q;
      filled_d    = filled_q;
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      head_ptr_d  = head_ptr_q;
      alloc_cnt_d = alloc_cnt_q;
      pend_cnt_d  = pend_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (flush) begin
         // Every unfilled request becomes a response to discard; a response
         // arriving this cycle already pays off one of them.
         filled_d    = '0;
         alloc_ptr_d = '0;
         fill_ptr_d  = '0;
         head_ptr_d  = '0;
         alloc_cnt_d = '0;
         pend_cnt_d  = '0;
         if (!imem_rvalid)
            drop_cnt_d = drop_sum[CW-1:0];
         else if (drop_sum != '0)
            drop_cnt_d = drop_sum_m1[CW-1:0];
         else
            drop_cnt_d = '0;
      end else begin
         if (drop_rsp)
            drop_cnt_d = drop_cnt_q - CW'(1);
         if (fill_rsp) begin
            inst_d[fill_ptr_q]   = imem_rdata;
            filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d           = fill_ptr_q + PW'(1);
         end
         if (pop) begin
            filled_d[head_ptr_q] = 1'b0;
            head_ptr_d           = head_ptr_q + PW'(1);
         end
         if (accept) begin
            pc_d[alloc_ptr_q]     = pc_in;
            filled_d[alloc_ptr_q] = 1'b0;
            alloc_ptr_d           = alloc_ptr_q + PW'(1);
         end
         case ({accept, pop})
            2'b10:   alloc_cnt_d = alloc_cnt_q + CW'(1);
            2'b01:   alloc_cnt_d = alloc_cnt_q - CW'(1);
            default: alloc_cnt_d = alloc_cnt_q;
         endcase
         case ({accept, fill_rsp})
            2'b10:   pend_cnt_d = pend_cnt_q + CW'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - CW'(1);
            default: pend_cnt_d = pend_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
         end
         filled_q    <= '0;
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         alloc_cnt_q <= '0;
         pend_cnt_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         filled_q    <= filled_d;
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         alloc_cnt_q <= alloc_cnt_d;
         pend_cnt_q  <= pend_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based model of the fetch buffer, a PC register
// and an in-order memory, with directed scenarios followed by random traffic.
module tb_ifetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        stall_out;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        id_ready;

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .stall_out(stall_out), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_pc(inst_pc), .id_ready(id_ready)
  );

  // model: buffered entries in program order, plus responses owed to killed requests
  logic [31:0] m_pc_q[$];
  logic [31:0] m_inst_q[$];
  bit          m_fill_q[$];
  int          m_drop;
  logic [31:0] mem_q[$];
  logic [31:0] pc_reg;
  logic [31:0] flush_target;
  bit          directed_data;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit e_req();
    return rst && !flush && ((m_pc_q.size() + m_drop) < DEPTH);
  endfunction

  function automatic bit e_stall();
    if (!rst) return 1'b1;
    if (flush) return 1'b0;
    return !(e_req() && imem_gnt);
  endfunction

  function automatic bit e_valid();
    return rst && (m_fill_q.size() > 0) && m_fill_q[0];
  endfunction

  task automatic model_reset();
    m_pc_q.delete(); m_inst_q.delete(); m_fill_q.delete();
    m_drop = 0;
    mem_q.delete();
    pc_reg = 32'h0;
  endtask

  task automatic compare_all();
    check("imem_req", imem_req, e_req());
    check("imem_addr", imem_addr, pc_reg);
    check("stall_out", stall_out, e_stall());
    check("inst_valid", inst_valid, e_valid());
    check("inst_out", inst_out, e_valid() ? m_inst_q[0] : NOP);
    check("inst_pc", inst_pc, e_valid() ? m_pc_q[0] : 32'h0);
  endtask

  task automatic model_update();
    bit acc, valid_now, stall_now, done;
    int unf;
    if (!rst) begin
      model_reset();
      return;
    end
    acc       = e_req() && imem_gnt;
    valid_now = e_valid();
    stall_now = e_stall();
    if (acc) mem_q.push_back(directed_data ? (32'hA000_0000 | pc_reg) : $urandom);
    if (flush) begin
      unf = 0;
      foreach (m_fill_q[i]) if (!m_fill_q[i]) unf++;
      m_drop = m_drop + unf - (imem_rvalid ? 1 : 0);
      if (m_drop < 0) m_drop = 0;
      m_pc_q.delete(); m_inst_q.delete(); m_fill_q.delete();
    end else begin
      if (imem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          done = 1'b0;
          foreach (m_fill_q[i]) begin
            if (!done && !m_fill_q[i]) begin
              m_fill_q[i] = 1'b1;
              m_inst_q[i] = imem_rdata;
              done = 1'b1;
            end
          end
        end
      end
      if (valid_now && id_ready) begin
        void'(m_pc_q.pop_front()); void'(m_inst_q.pop_front()); void'(m_fill_q.pop_front());
      end
      if (acc) begin
        m_pc_q.push_back(pc_reg); m_inst_q.push_back(32'h0); m_fill_q.push_back(1'b0);
      end
    end
    if (flush) pc_reg = flush_target;
    else if (!stall_now) pc_reg = pc_reg + 32'd4;
  endtask

  // rv_mode: 0 none, 1 return the oldest owed response, 2 spurious response
  task automatic drive(input bit gnt, input int rv_mode, input bit rdy, input bit fl,
                       input logic [31:0] tgt);
    imem_gnt     = gnt;
    id_ready     = rdy;
    flush        = fl;
    flush_target = tgt;
    pc_in        = pc_reg;
    imem_rvalid  = 1'b0;
    imem_rdata   = $urandom;
    if (rv_mode == 1 && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q.pop_front();
    end else if (rv_mode == 2) begin
      imem_rvalid = 1'b1;
    end
  endtask

  task automatic half_check();
    @(negedge clk);
    compare_all();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle(input bit gnt, input int rv_mode, input bit rdy, input bit fl,
                       input logic [31:0] tgt);
    drive(gnt, rv_mode, rdy, fl, tgt);
    half_check();
    commit();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; pc_in = '0; flush_target = '0; directed_data = 1'b1;
    model_reset();

    // reset state
    drive(1, 0, 1, 0, 0);
    half_check();
    check("rst_req", imem_req, 32'd0);
    check("rst_stall", stall_out, 32'd1);
    check("rst_valid", inst_valid, 32'd0);
    check("rst_inst", inst_out, 32'h0000_0013);
    check("rst_pc", inst_pc, 32'd0);
    commit();
    cycle(1, 0, 1, 0, 0);
    rst = 1'b1;

    // back-to-back stream with 1-cycle memory
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 1, 0, 0);
      half_check();
      if (k == 0) begin
        check("first_req", imem_req, 32'd1);
        check("first_addr", imem_addr, 32'd0);
      end
      check("stream_stall", stall_out, 32'd0);
      if (k >= 2) begin
        check("stream_valid", inst_valid, 32'd1);
        check("stream_pc", inst_pc, 32'((k - 2) * 4));
        check("stream_inst", inst_out, 32'hA000_0000 | 32'((k - 2) * 4));
      end
      commit();
    end
    repeat (6) cycle(0, 1, 1, 0, 0);

    // decode stalled: buffer fills, then one pop frees exactly one request
    for (int j = 0; j < 9; j++) begin
      drive(1, 1, (j == 6), 0, 0);
      half_check();
      if (j == 4 || j == 5) begin
        check("full_req", imem_req, 32'd0);
        check("full_stall", stall_out, 32'd1);
      end
      if (j == 6) check("pop_req", imem_req, 32'd0);
      if (j == 7) begin
        check("resume_req", imem_req, 32'd1);
        check("resume_stall", stall_out, 32'd0);
      end
      if (j == 8) check("refull_req", imem_req, 32'd0);
      commit();
    end
    repeat (8) cycle(0, 1, 1, 0, 0);

    // grant withheld at 0x40
    drive(0, 1, 1, 1, 32'h40);
    half_check();
    check("flush_stall", stall_out, 32'd0);
    commit();
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0, 0, 0);
      half_check();
      check("nogrant_stall", stall_out, 32'd1);
      check("nogrant_addr", imem_addr, 32'h40);
      check("nogrant_req", imem_req, 32'd1);
      commit();
    end
    drive(1, 0, 0, 0, 0);
    half_check();
    check("grant_stall", stall_out, 32'd0);
    commit();
    cycle(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    half_check();
    check("grant_valid", inst_valid, 32'd1);
    check("grant_pc", inst_pc, 32'h40);
    check("grant_inst", inst_out, 32'hA000_0040);
    commit();
    cycle(0, 0, 1, 0, 0);

    // flush with two outstanding and a response in the same cycle
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    drive(0, 1, 1, 1, 32'h100);
    half_check();
    check("kill_req", imem_req, 32'd0);
    check("kill_stall", stall_out, 32'd0);
    commit();
    drive(1, 1, 1, 0, 0);
    half_check();
    check("drop_valid", inst_valid, 32'd0);
    check("drop_addr", imem_addr, 32'h100);
    commit();
    drive(0, 1, 0, 0, 0);
    half_check();
    check("drop_valid2", inst_valid, 32'd0);
    commit();
    drive(0, 0, 0, 0, 0);
    half_check();
    check("target_valid", inst_valid, 32'd1);
    check("target_pc", inst_pc, 32'h100);
    commit();
    cycle(0, 0, 1, 0, 0);

    // spurious response into an empty buffer
    drive(0, 2, 1, 0, 0);
    half_check();
    check("spur_valid", inst_valid, 32'd0);
    commit();
    drive(0, 0, 1, 0, 0);
    half_check();
    check("spur_after_valid", inst_valid, 32'd0);
    check("spur_after_req", imem_req, 32'd1);
    commit();

    // asynchronous reset with two requests outstanding
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("async_req", imem_req, 32'd0);
    check("async_valid", inst_valid, 32'd0);
    check("async_inst", inst_out, 32'h0000_0013);
    model_reset();
    pc_in = 32'h0;
    commit();
    cycle(1, 0, 0, 0, 0);
    rst = 1'b1;
    drive(1, 1, 1, 0, 0);
    half_check();
    check("rerst_req", imem_req, 32'd1);
    check("rerst_addr", imem_addr, 32'd0);
    commit();

    // random traffic
    directed_data = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int rv_mode;
      bit g, r, f;
      g = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 19) == 0);
      if (mem_q.size() > 0) rv_mode = ($urandom_range(0, 3) != 0) ? 1 : 0;
      else rv_mode = ($urandom_range(0, 15) == 0) ? 2 : 0;
      rst = ($urandom_range(0, 499) != 0);
      cycle(g, rv_mode, r, f, $urandom & 32'hFFFF_FFFC);
    end
    rst = 1'b1;
    repeat (10) cycle(0, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end sitting between the program counter register and instruction memory. It takes the current fetch address from the PC, issues in-order requests over a req/gnt/rvalid memory port, and buffers returned instructions with their PCs for the decode stage. It drives the active-high stall input of the PC register whenever a fetch address is not accepted. On a redirect it drops wrong-path responses still in flight.

## Interface
- DEPTH, 4, entries in the in-order fetch buffer and maximum outstanding requests (power of 2, ≥2)
- NOP, 32'h0000_0013, value driven on inst_out when inst_valid=0
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_in  in  32  current fetch address from PC register
- stall_out  out  1  to PC stall input; 1 = PC holds
- flush  in  1  redirect/kill; PC loads a new target this cycle
- imem_req  out  1  request valid
- imem_addr  out  32  request address (= pc_in)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  32  response instruction
- inst_valid  out  1  head instruction available to decode
- inst_out  out  32  head instruction
- inst_pc  out  32  PC of head instruction
- id_ready  in  1  decode consumes head when inst_valid & id_ready

## Operation
- Buffer: DEPTH entries {pc, inst, filled}; alloc pointer, fill pointer, head pointer, each log2(DEPTH) bits, wrapping modulo DEPTH; alloc_cnt = entries allocated and not popped (0..DEPTH).
- drop_cnt: responses still owed for killed requests (0..DEPTH).
- Occupancy = alloc_cnt + drop_cnt, from registered state only (no same-cycle pop credit).
- imem_req = rst high & ~flush & (occupancy < DEPTH); imem_addr = pc_in always.
- accept = imem_req & imem_gnt: allocate entry at alloc pointer with pc=pc_in, filled=0.
- stall_out = ~accept, including the reset/low-credit cases; exception: stall_out=0 during a flush cycle so the PC loads the redirect target.
- imem_rvalid with drop_cnt>0: decrement drop_cnt, discard data. Otherwise, if an unfilled allocated entry exists: write inst at fill pointer, set filled, advance fill pointer. Otherwise: spurious, ignored, no state change.
- inst_valid = head entry filled; inst_out/inst_pc from head, inst_out=NOP and inst_pc=0 when invalid.
- Pop when inst_valid & id_ready & ~flush: clear entry, advance head, decrement alloc_cnt.
- Flush: all entries cleared, pointers reset to equal, alloc_cnt=0; drop_cnt_next = drop_cnt + unfilled_allocated − (imem_rvalid ? 1 : 0), saturating at 0. No request, no pop in that cycle; flush wins over simultaneous pop, fill, and accept.

## Timing
- Reset (rst=0, async): all pointers, counters, filled bits = 0; imem_req=0, stall_out=1, inst_valid=0, inst_out=NOP, inst_pc=0.
- First request: first cycle after rst rises, imem_req=1 with imem_addr=pc_in.
- Earliest rvalid: cycle after gnt. Fill is registered, so inst_valid rises the cycle after rvalid.
- Accept at N, rvalid at N+1 -> inst_valid at N+2.
- Sustained one fetch per cycle with 1-cycle memory and id_ready=1 requires DEPTH ≥ 3.
- Buffer full (occupancy=DEPTH): imem_req=0, stall_out=1 until a pop or dropped response frees a slot; the request resumes the cycle after.
- imem_gnt=0 with imem_req=1: imem_req stays 1 and imem_addr stays stable, because the PC is stalled.

## Test plan
- Reset with rst=0 mid-stream (2 outstanding) -> next edge-independent: imem_req=0, inst_valid=0, inst_out=0x00000013; after release, first request at addr=pc_in=0.
- PC 0,4,8,12, gnt=1, rvalid one cycle later with rdata=A0..A3, id_ready=1 -> inst_valid from cycle 3, inst_pc 0,4,8,12 with inst_out A0..A3 back-to-back, stall_out=0 throughout.
- id_ready=0, gnt=1, 1-cycle memory -> after 4 accepts stall_out=1, imem_req=0. Then id_ready=1 for one cycle -> exactly one new request the following cycle.
- gnt held 0 for 3 cycles at pc=0x40 -> stall_out=1, imem_addr=0x40 stable; gnt=1 -> entry pc=0x40 allocated.
- 2 requests outstanding, flush with rvalid in the same cycle -> drop_cnt=1. The next rvalid is discarded and inst_valid stays 0 until a post-flush request (pc=target 0x100) returns, then inst_pc=0x100.
- Spurious rvalid with buffer empty and drop_cnt=0 -> no inst_valid, counters unchanged.
